// File: rtl/lpif_txrx_pkg.sv
// rtl/lpif_txrx_pkg.sv - shared lane widths, beat/word structs and pack FSM states
package lpif_txrx_pkg;

  localparam int STATE_W     = 4;
  localparam int PROTID_W    = 2;
  localparam int DATA_W      = 64;
  localparam int DVALID_W    = 1;
  localparam int CRC_W       = 2;
  localparam int CRC_VALID_W = 1;
  localparam int VALID_W     = 1;
  localparam int LANES       = 2;
  localparam int CNT_W       = 8;

  // One LPIF beat, 75 bits.
  typedef struct packed {
    logic [STATE_W-1:0]     state;
    logic [PROTID_W-1:0]    protid;
    logic [DATA_W-1:0]      data;
    logic [DVALID_W-1:0]    dvalid;
    logic [CRC_W-1:0]       crc;
    logic [CRC_VALID_W-1:0] crc_valid;
    logic [VALID_W-1:0]     valid;
  } lpif_beat_t;

  typedef struct packed {
    lpif_beat_t       lane1;
    lpif_beat_t       lane0;
    logic [LANES-1:0] mask;
  } x2_word_t;

  typedef enum logic {
    PACK_EMPTY = 1'b0,
    PACK_HALF  = 1'b1
  } pack_st_e;

  // A lone beat always sits in lane 0 with lane 1 zeroed.
  function automatic x2_word_t make_word(input lpif_beat_t l0, input lpif_beat_t l1,
                                         input logic pair);
    x2_word_t w;
    w.lane0 = l0;
    w.lane1 = pair ? l1 : '0;
    w.mask  = pair ? 2'b11 : 2'b01;
    return w;
  endfunction

endpackage

// File: rtl/lpif_txrx_x2_beat_pack_if.sv
// rtl/lpif_txrx_x2_beat_pack_if.sv - beat input, x2 word output and status signals of the packer
interface lpif_txrx_x2_beat_pack_if;
  import lpif_txrx_pkg::*;

  logic                         m_gen2_mode;
  logic                         in_vld;
  logic                         in_rdy;
  logic [STATE_W-1:0]           in_state;
  logic [PROTID_W-1:0]          in_protid;
  logic [DATA_W-1:0]            in_data;
  logic [DVALID_W-1:0]          in_dvalid;
  logic [CRC_W-1:0]             in_crc;
  logic [CRC_VALID_W-1:0]       in_crc_valid;
  logic [VALID_W-1:0]           in_valid;
  logic [LANES*STATE_W-1:0]     dstrm_state;
  logic [LANES*PROTID_W-1:0]    dstrm_protid;
  logic [LANES*DATA_W-1:0]      dstrm_data;
  logic [LANES*DVALID_W-1:0]    dstrm_dvalid;
  logic [LANES*CRC_W-1:0]       dstrm_crc;
  logic [LANES*CRC_VALID_W-1:0] dstrm_crc_valid;
  logic [LANES*VALID_W-1:0]     dstrm_valid;
  logic [LANES-1:0]             dstrm_lane_mask;
  logic                         dstrm_push;
  logic                         dstrm_rdy;
  logic                         pack_busy;

  modport master (
    output m_gen2_mode, in_vld, in_state, in_protid, in_data, in_dvalid, in_crc,
           in_crc_valid, in_valid, dstrm_rdy,
    input  in_rdy, dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
           dstrm_crc_valid, dstrm_valid, dstrm_lane_mask, dstrm_push, pack_busy
  );

  modport slave (
    input  m_gen2_mode, in_vld, in_state, in_protid, in_data, in_dvalid, in_crc,
           in_crc_valid, in_valid, dstrm_rdy,
    output in_rdy, dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
           dstrm_crc_valid, dstrm_valid, dstrm_lane_mask, dstrm_push, pack_busy
  );

endinterface

// File: rtl/lpif_txrx_beat_oreg.sv
// rtl/lpif_txrx_beat_oreg.sv - x2 output word register with full flag; holds while stalled
module lpif_txrx_beat_oreg
  import lpif_txrx_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  x2_word_t word,
  input  logic     rdy,
  output logic     full,
  output logic     load_ok,
  output x2_word_t q
);

  // A drain and a refill may coincide; the refill wins.
  assign load_ok = !full || rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load && load_ok) begin
      full <= 1'b1;
      q    <= word;
    end else if (full && rdy) begin
      full <= 1'b0;
      q    <= '0;
    end
  end

endmodule

// File: rtl/lpif_txrx_x2_beat_pack.sv
// rtl/lpif_txrx_x2_beat_pack.sv - packs single LPIF beats into two-lane x2 words with flush timer
module lpif_txrx_x2_beat_pack
  import lpif_txrx_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                      clk_wr,
  input  logic                      rst_wr_n,
  lpif_txrx_x2_beat_pack_if.slave   pk
);

  localparam logic [CNT_W-1:0] FLUSH_MAX = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_THR = CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  pack_st_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lpif_beat_t       hold_q, hold_d;
  lpif_beat_t       beat_in;
  x2_word_t         word_d, oq;
  logic             load, load_ok, oreg_full, in_rdy;

  // Async assert, release two clocks later; in_rdy stays low until then.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign beat_in = '{state: pk.in_state, protid: pk.in_protid, data: pk.in_data,
                     dvalid: pk.in_dvalid, crc: pk.in_crc, crc_valid: pk.in_crc_valid,
                     valid: pk.in_valid};

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PACK_EMPTY;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    in_rdy  = 1'b0;
    load    = 1'b0;
    word_d  = '0;
    case (state_q)
      PACK_EMPTY: begin
        in_rdy = rst_n && (pk.m_gen2_mode || load_ok);
        if (pk.in_vld && in_rdy) begin
          if (pk.m_gen2_mode) begin
            hold_d  = beat_in;
            cnt_d   = '0;
            state_d = PACK_HALF;
          end else begin
            load   = 1'b1;
            word_d = make_word(beat_in, hold_q, 1'b0);
          end
        end
      end
      PACK_HALF: begin
        if (!pk.m_gen2_mode) begin
          // Leaving gen2 with a held beat: flush it before taking anything new.
          if (load_ok) begin
            load    = 1'b1;
            word_d  = make_word(hold_q, beat_in, 1'b0);
            state_d = PACK_EMPTY;
          end
        end else begin
          in_rdy = load_ok;
          if (pk.in_vld && load_ok) begin
            load    = 1'b1;
            word_d  = make_word(hold_q, beat_in, 1'b1);
            state_d = PACK_EMPTY;
          end else begin
            if (cnt_q < FLUSH_MAX) cnt_d = cnt_q + 8'd1;
            if (cnt_q >= FLUSH_THR && load_ok) begin
              load    = 1'b1;
              word_d  = make_word(hold_q, beat_in, 1'b0);
              state_d = PACK_EMPTY;
            end
          end
        end
      end
      default: state_d = PACK_EMPTY;
    endcase
  end

  lpif_txrx_beat_oreg u_oreg (
    .clk     (clk_wr),
    .rst_n   (rst_n),
    .load    (load),
    .word    (word_d),
    .rdy     (pk.dstrm_rdy),
    .full    (oreg_full),
    .load_ok (load_ok),
    .q       (oq)
  );

  assign pk.in_rdy          = in_rdy;
  assign pk.dstrm_state     = {oq.lane1.state, oq.lane0.state};
  assign pk.dstrm_protid    = {oq.lane1.protid, oq.lane0.protid};
  assign pk.dstrm_data      = {oq.lane1.data, oq.lane0.data};
  assign pk.dstrm_dvalid    = {oq.lane1.dvalid, oq.lane0.dvalid};
  assign pk.dstrm_crc       = {oq.lane1.crc, oq.lane0.crc};
  assign pk.dstrm_crc_valid = {oq.lane1.crc_valid, oq.lane0.crc_valid};
  assign pk.dstrm_valid     = {oq.lane1.valid, oq.lane0.valid};
  assign pk.dstrm_lane_mask = oq.mask;
  assign pk.dstrm_push      = oreg_full;
  assign pk.pack_busy       = (state_q == PACK_HALF) || oreg_full;

endmodule

// File: tb/tb_lpif_txrx_x2_beat_pack.sv
// tb/tb_lpif_txrx_x2_beat_pack.sv - directed self-checking bench for the x2 beat packer
module tb_lpif_txrx_x2_beat_pack;

  logic clk_wr = 1'b0;
  logic rst_wr_n;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] q_data[$];
  logic [1:0]   q_mask[$];

  always #5 clk_wr = ~clk_wr;

  lpif_txrx_x2_beat_pack_if bus();

  lpif_txrx_x2_beat_pack #(.FLUSH_CYCLES(4)) dut (
    .clk_wr   (clk_wr),
    .rst_wr_n (rst_wr_n),
    .pk       (bus)
  );

  always @(negedge clk_wr) begin
    if (rst_wr_n && bus.dstrm_push && bus.dstrm_rdy) begin
      q_data.push_back(bus.dstrm_data);
      q_mask.push_back(bus.dstrm_lane_mask);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic set_beat(input logic [63:0] d);
    bus.in_vld       = 1'b1;
    bus.in_data      = d;
    bus.in_state     = d[3:0];
    bus.in_protid    = d[5:4];
    bus.in_dvalid    = 1'b1;
    bus.in_crc       = d[7:6];
    bus.in_crc_valid = 1'b1;
    bus.in_valid     = 1'b1;
  endtask

  task automatic idle();
    bus.in_vld       = 1'b0;
    bus.in_data      = '0;
    bus.in_state     = '0;
    bus.in_protid    = '0;
    bus.in_dvalid    = '0;
    bus.in_crc       = '0;
    bus.in_crc_valid = '0;
    bus.in_valid     = '0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_mask.delete();
  endtask

  task automatic test_reset();
    logic [127:0] exp;
    repeat (2) cyc();
    @(negedge clk_wr);
    checks++; if (bus.dstrm_push !== 1'b0) begin errors++; $display("FAIL rst_push got %0h exp 0", bus.dstrm_push); end
    checks++; if (bus.dstrm_lane_mask !== 2'b00) begin errors++; $display("FAIL rst_mask got %0h exp 0", bus.dstrm_lane_mask); end
    checks++; if (bus.dstrm_data !== 128'h0) begin errors++; $display("FAIL rst_data got %0h exp 0", bus.dstrm_data); end
    checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy got %0h exp 0", bus.in_rdy); end
    cyc();
    rst_wr_n = 1'b1;
    repeat (3) cyc();
    @(negedge clk_wr);
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rel_in_rdy got %0h exp 1", bus.in_rdy); end
    cyc();
    set_beat(64'h55);
    cyc();
    idle();
    cyc();
    #2 rst_wr_n = 1'b0;
    #1;
    checks++; if (bus.dstrm_push !== 1'b0) begin errors++; $display("FAIL midrst_push got %0h exp 0", bus.dstrm_push); end
    checks++; if (bus.pack_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0h exp 0", bus.pack_busy); end
    checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL midrst_in_rdy got %0h exp 0", bus.in_rdy); end
    checks++; if (bus.dstrm_data !== 128'h0) begin errors++; $display("FAIL midrst_data got %0h exp 0", bus.dstrm_data); end
    cyc();
    rst_wr_n = 1'b1;
    repeat (3) cyc();
    clear_q();
    set_beat(64'h9);
    cyc();
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_wr);
      checks++; if (bus.dstrm_push !== 1'b0) begin errors++; $display("FAIL postrst_idle%0d push got %0h exp 0", k, bus.dstrm_push); end
      cyc();
    end
    @(negedge clk_wr);
    exp = {64'h0, 64'h9};
    checks++; if (bus.dstrm_data !== exp) begin errors++; $display("FAIL postrst_flush_data got %0h exp %0h", bus.dstrm_data, exp); end
    cyc();
    checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL postrst_words got %0d exp 1", q_data.size()); end
  endtask

  task automatic test_gen2_pair();
    logic [127:0] exp;
    bus.m_gen2_mode = 1'b1;
    bus.dstrm_rdy   = 1'b1;
    clear_q();
    set_beat(64'h1);
    @(negedge clk_wr);
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL pair_rdy0 got %0h exp 1", bus.in_rdy); end
    cyc();
    set_beat(64'h2);
    @(negedge clk_wr);
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL pair_rdy1 got %0h exp 1", bus.in_rdy); end
    checks++; if (bus.dstrm_push !== 1'b0) begin errors++; $display("FAIL pair_early_push got %0h exp 0", bus.dstrm_push); end
    cyc();
    idle();
    @(negedge clk_wr);
    exp = {64'h2, 64'h1};
    checks++; if (bus.dstrm_push !== 1'b1) begin errors++; $display("FAIL pair_push got %0h exp 1", bus.dstrm_push); end
    checks++; if (bus.dstrm_data !== exp) begin errors++; $display("FAIL pair_data got %0h exp %0h", bus.dstrm_data, exp); end
    checks++; if (bus.dstrm_lane_mask !== 2'b11) begin errors++; $display("FAIL pair_mask got %0h exp 3", bus.dstrm_lane_mask); end
    checks++; if (bus.dstrm_state !== 8'h21) begin errors++; $display("FAIL pair_state got %0h exp 21", bus.dstrm_state); end
    checks++; if (bus.dstrm_crc_valid !== 2'b11) begin errors++; $display("FAIL pair_crc_valid got %0h exp 3", bus.dstrm_crc_valid); end
    cyc();
    @(negedge clk_wr);
    checks++; if (bus.dstrm_push !== 1'b0) begin errors++; $display("FAIL pair_push_once got %0h exp 0", bus.dstrm_push); end
    checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL pair_words got %0d exp 1", q_data.size()); end
    cyc();
  endtask

  task automatic test_flush();
    logic [127:0] exp;
    clear_q();
    set_beat(64'hA);
    cyc();
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_wr);
      checks++; if (bus.dstrm_push !== 1'b0) begin errors++; $display("FAIL flush_wait%0d push got %0h exp 0", k, bus.dstrm_push); end
      cyc();
    end
    @(negedge clk_wr);
    exp = {64'h0, 64'hA};
    checks++; if (bus.dstrm_push !== 1'b1) begin errors++; $display("FAIL flush_push got %0h exp 1", bus.dstrm_push); end
    checks++; if (bus.dstrm_data !== exp) begin errors++; $display("FAIL flush_data got %0h exp %0h", bus.dstrm_data, exp); end
    checks++; if (bus.dstrm_lane_mask !== 2'b01) begin errors++; $display("FAIL flush_mask got %0h exp 1", bus.dstrm_lane_mask); end
    checks++; if (bus.dstrm_state !== 8'h0A) begin errors++; $display("FAIL flush_state got %0h exp 0a", bus.dstrm_state); end
    checks++; if (bus.dstrm_dvalid !== 2'b01) begin errors++; $display("FAIL flush_dvalid got %0h exp 1", bus.dstrm_dvalid); end
    cyc();
    @(negedge clk_wr);
    checks++; if (bus.pack_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0h exp 0", bus.pack_busy); end
    cyc();
  endtask

  task automatic test_backpressure();
    int i;
    logic [127:0] exp;
    logic [127:0] exp_w[3];
    i = 1;
    exp_w[0] = {64'h2, 64'h1};
    exp_w[1] = {64'h4, 64'h3};
    exp_w[2] = {64'h6, 64'h5};
    bus.m_gen2_mode = 1'b1;
    bus.dstrm_rdy   = 1'b0;
    clear_q();
    for (int c = 0; c < 6; c++) begin
      set_beat(64'(i));
      @(negedge clk_wr);
      checks++; if (bus.in_rdy !== (c < 3)) begin errors++; $display("FAIL bp_in_rdy_c%0d got %0h exp %0h", c, bus.in_rdy, (c < 3)); end
      if (bus.in_rdy) i++;
      cyc();
    end
    @(negedge clk_wr);
    exp = {64'h2, 64'h1};
    checks++; if (bus.dstrm_data !== exp) begin errors++; $display("FAIL bp_stable_data got %0h exp %0h", bus.dstrm_data, exp); end
    checks++; if (bus.dstrm_push !== 1'b1) begin errors++; $display("FAIL bp_stable_push got %0h exp 1", bus.dstrm_push); end
    checks++; if (bus.pack_busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %0h exp 1", bus.pack_busy); end
    cyc();
    bus.dstrm_rdy = 1'b1;
    for (int c = 0; c < 20 && i <= 6; c++) begin
      set_beat(64'(i));
      @(negedge clk_wr);
      if (bus.in_rdy) i++;
      cyc();
    end
    idle();
    repeat (4) cyc();
    checks++; if (i !== 7) begin errors++; $display("FAIL bp_all_accepted got %0d exp 7", i); end
    checks++; if (q_data.size() !== 3) begin errors++; $display("FAIL bp_words got %0d exp 3", q_data.size()); end
    for (int k = 0; k < 3 && k < q_data.size(); k++) begin
      checks++; if (q_data[k] !== exp_w[k]) begin errors++; $display("FAIL bp_word%0d got %0h exp %0h", k, q_data[k], exp_w[k]); end
      checks++; if (q_mask[k] !== 2'b11) begin errors++; $display("FAIL bp_mask%0d got %0h exp 3", k, q_mask[k]); end
    end
  endtask

  task automatic test_gen1();
    logic [127:0] exp;
    bus.m_gen2_mode = 1'b0;
    bus.dstrm_rdy   = 1'b1;
    clear_q();
    for (int k = 0; k < 3; k++) begin
      set_beat(64'h10 + 64'(k));
      @(negedge clk_wr);
      checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL gen1_rdy%0d got %0h exp 1", k, bus.in_rdy); end
      if (k > 0) begin
        exp = {64'h0, 64'h10 + 64'(k - 1)};
        checks++; if (bus.dstrm_data !== exp) begin errors++; $display("FAIL gen1_word%0d got %0h exp %0h", k - 1, bus.dstrm_data, exp); end
        checks++; if (bus.dstrm_lane_mask !== 2'b01) begin errors++; $display("FAIL gen1_mask%0d got %0h exp 1", k - 1, bus.dstrm_lane_mask); end
      end
      cyc();
    end
    idle();
    @(negedge clk_wr);
    exp = {64'h0, 64'h12};
    checks++; if (bus.dstrm_data !== exp) begin errors++; $display("FAIL gen1_word2 got %0h exp %0h", bus.dstrm_data, exp); end
    cyc();
    @(negedge clk_wr);
    checks++; if (bus.dstrm_push !== 1'b0) begin errors++; $display("FAIL gen1_drained got %0h exp 0", bus.dstrm_push); end
    checks++; if (q_data.size() !== 3) begin errors++; $display("FAIL gen1_words got %0d exp 3", q_data.size()); end
    cyc();
  endtask

  task automatic test_mode_switch();
    logic [127:0] exp;
    bus.m_gen2_mode = 1'b1;
    bus.dstrm_rdy   = 1'b1;
    clear_q();
    set_beat(64'h7);
    cyc();
    bus.m_gen2_mode = 1'b0;
    set_beat(64'h8);
    @(negedge clk_wr);
    checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL ms_in_rdy got %0h exp 0", bus.in_rdy); end
    checks++; if (bus.pack_busy !== 1'b1) begin errors++; $display("FAIL ms_busy got %0h exp 1", bus.pack_busy); end
    cyc();
    @(negedge clk_wr);
    exp = {64'h0, 64'h7};
    checks++; if (bus.dstrm_data !== exp) begin errors++; $display("FAIL ms_flush_data got %0h exp %0h", bus.dstrm_data, exp); end
    checks++; if (bus.dstrm_lane_mask !== 2'b01) begin errors++; $display("FAIL ms_flush_mask got %0h exp 1", bus.dstrm_lane_mask); end
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL ms_gen1_rdy got %0h exp 1", bus.in_rdy); end
    cyc();
    idle();
    @(negedge clk_wr);
    exp = {64'h0, 64'h8};
    checks++; if (bus.dstrm_data !== exp) begin errors++; $display("FAIL ms_gen1_data got %0h exp %0h", bus.dstrm_data, exp); end
    checks++; if (bus.dstrm_lane_mask !== 2'b01) begin errors++; $display("FAIL ms_gen1_mask got %0h exp 1", bus.dstrm_lane_mask); end
    cyc();
    @(negedge clk_wr);
    checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL ms_words got %0d exp 2", q_data.size()); end
  endtask

  initial begin
    idle();
    bus.m_gen2_mode = 1'b1;
    bus.dstrm_rdy   = 1'b1;
    rst_wr_n        = 1'b1;
    #2 rst_wr_n     = 1'b0;
    test_reset();
    test_gen2_pair();
    test_flush();
    test_backpressure();
    test_gen1();
    test_mode_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpif_txrx_x2_beat_pack.md
# lpif_txrx_x2_beat_pack

Single-clock packer that sits directly upstream of the x2 asym1 half-rate LPIF TX mapper. It collects single LPIF beats (one state/protid/data/dvalid/crc/crc_valid/valid slice per beat) into two-lane x2 words and presents them with a push/ready handshake to the mapper's `dstrm_*` inputs. In gen1 mode it forwards each beat alone in lane 0. A programmable flush timer emits a half-filled word so a lone beat never stalls.

## Interface
- `FLUSH_CYCLES`, 4: idle cycles in HALF before lane 0 is emitted alone; legal range 1..255.
- `clk_wr`  in  1  write-domain clock.
- `rst_wr_n`  in  1  asynchronous active-low reset.
- `m_gen2_mode`  in  1  1 = pair beats into lanes 0/1; 0 = lane 0 only.
- `in_vld`  in  1  beat offered.
- `in_rdy`  out  1  beat accepted when `in_vld && in_rdy`.
- `in_state`  in  4  beat fields, each mapped into one lane of the matching `dstrm_*` bus.
- `in_protid`  in  2
- `in_data`  in  64
- `in_dvalid`  in  1
- `in_crc`  in  2
- `in_crc_valid`  in  1
- `in_valid`  in  1
- `dstrm_state`  out  8; `dstrm_protid`  out  4; `dstrm_data`  out  128; `dstrm_dvalid`  out  2; `dstrm_crc`  out  4; `dstrm_crc_valid`  out  2; `dstrm_valid`  out  2: lane k = bits [k*w +: w].
- `dstrm_lane_mask`  out  2  occupied lanes: 2'b01 or 2'b11.
- `dstrm_push`  out  1  output word valid.
- `dstrm_rdy`  in  1  consumer takes word when `dstrm_push && dstrm_rdy`.
- `pack_busy`  out  1  HALF state or output register full.

## Operation
- Pack FSM states:
  - EMPTY: no beat held.
  - HALF: lane-0 beat held in the `hold` register.
- Output register (`oreg`) has a full flag. `dstrm_push` = full flag.
- `load_ok` = `!oreg_full || dstrm_rdy`. Drain and refill in the same cycle are allowed.
- `in_rdy` rules:
  - EMPTY with `m_gen2_mode`=1: `in_rdy` = 1. The beat goes into `hold` and does not need `oreg`.
  - Otherwise: `in_rdy` = `load_ok`.
- EMPTY, gen2, accept: capture beat into `hold`, clear flush counter, go to HALF.
- EMPTY, gen1, accept: load `oreg` with the beat in lane 0 and zeros in lane 1; mask 2'b01; stay in EMPTY.
- HALF, accept: load `oreg` with lane 0 = `hold` and lane 1 = the new beat; mask 2'b11; go to EMPTY.
- HALF, no accept:
  - Counter increments, saturating at `FLUSH_CYCLES`.
  - When counter ≥ `FLUSH_CYCLES-1` and `load_ok`: load `oreg` with `hold` in lane 0, zeros in lane 1, mask 2'b01; go to EMPTY.
  - If `oreg` is blocked, the flush waits. `in_rdy` stays governed by `load_ok`, so a second beat arriving while the flush waits still pairs normally.
- Mode change:
  - `m_gen2_mode` is sampled every cycle.
  - Falling to 0 while in HALF forces an immediate flush, with `in_rdy`=0 that cycle.
  - Rising to 1 takes effect at the next accept in EMPTY.
- Beat order is preserved; lane 0 is always the older beat.
- Outputs are driven only from `oreg`; lane fields of unoccupied lanes are zero.

## Timing
- Reset (async assert, sync deassert inside the block):
  - State EMPTY, counter 0, `hold` 0.
  - `oreg` 0 and not full, so all `dstrm_*` = 0, `dstrm_lane_mask` = 0, `dstrm_push` = 0.
  - `in_rdy` = 0 while in reset, then 1.
- Latency:
  - gen1: word visible the cycle after accept.
  - gen2 pair: visible the cycle after the second beat is accepted.
  - Flush: visible `FLUSH_CYCLES` cycles after the lone beat's accept, when unblocked.
- Throughput:
  - gen1: one word per cycle.
  - gen2: one word per two beats, with back-to-back accepts every cycle.
- Reset mid-operation: `hold` and `oreg` contents are discarded; no partial word is emitted after reset release.
- `dstrm_*` hold stable while `dstrm_push && !dstrm_rdy`.

## Structure
- Shared package (`lpif_txrx_pkg`):
  - Lane field widths: 4/2/64/1/2/1/1, 75 bits per lane.
  - Beat struct `lpif_beat_t`.
  - FSM enum `pack_st_e`.
- One sub-module: `lpif_txrx_beat_oreg`, the output register with full flag, `load_ok` and hold-on-stall.
- FSM, flush counter and `hold` stay in the top.

## Test plan
- Reset:
  - Stimulus: assert `rst_wr_n`=0 mid-HALF.
  - Response: `dstrm_push`=0, all outputs 0; after release, one beat plus 3 idle cycles plus no further beats gives no stale output.
- gen2 pairing:
  - Stimulus: beats with `in_data`=0x1, then 0x2, on consecutive cycles, `dstrm_rdy`=1.
  - Response: one cycle later `dstrm_data`=`{64'h2,64'h1}`, mask 2'b11, `dstrm_push` high for 1 cycle.
- Flush:
  - Stimulus: single beat `in_data`=0xA, `FLUSH_CYCLES`=4.
  - Response: push 4 cycles after accept; lane0 data 0xA, lane1 all zero, mask 2'b01.
- Backpressure:
  - Stimulus: `dstrm_rdy`=0 with 6 beats offered in gen2.
  - Response: `in_rdy` drops after the 3rd beat is held; outputs stable; on `dstrm_rdy`=1, words {2,1},{4,3},{6,5} in order, nothing lost or duplicated.
- gen1:
  - Stimulus: 3 beats back-to-back, `dstrm_rdy`=1.
  - Response: 3 words, each mask 2'b01, one per cycle, latency 1.
- Mode switch:
  - Stimulus: `m_gen2_mode` 1→0 while in HALF holding 0x7.
  - Response: immediate lane-0-only word 0x7 with `in_rdy`=0 that cycle; subsequent beats pass in gen1 form.
